mru_value_tracker: RTL
======================

// Module: mru_value_tracker
// PURPOSE
//   Tracks the DEPTH most-recently-seen DISTINCT values of a sampled data stream,
//   ordered newest (slot 0) to oldest (slot DEPTH-1), with move-to-front on repeat.
//   Parametrised in width and depth; explicit input qualifier, synchronous clear,
//   hit reporting and fill-state tracking. Sits after the input capture stage,
//   feeding history/lookup consumers.
// PARAMETERS
//   DATA_W  8  width of each tracked value
//   DEPTH   4  number of history slots; legal range 2..32
// PORTS
//   clk_in         in   1               clock; all logic on rising edge
//   reset_in       in   1               asynchronous, active-high reset
//   data_in        in   DATA_W          sample value
//   data_valid_in  in   1               qualifies data_in this cycle
//   clear_in       in   1               synchronous flush of all slots
//   out_data       out  DEPTH*DATA_W    slot k at [k*DATA_W +: DATA_W]; slot 0 newest
//   out_valid      out  DEPTH           bit k = slot k holds a value
//   count_out      out  $clog2(DEPTH+1) number of valid slots
//   hit_out        out  1               pulse: last accepted sample matched a slot
//   hit_idx_out    out  $clog2(DEPTH)   slot index matched (valid with hit_out)
// BEHAVIOUR
//   - Clock clk_in; reset_in asynchronous, active-high. On assertion (any time,
//     incl. mid-update) all outputs go to 0 immediately: out_data, out_valid,
//     count_out, hit_out, hit_idx_out; FSM -> ST_EMPTY.
//   - Accept: data_valid_in=1 and clear_in=0 at a rising edge. Latency 1 cycle:
//     updated list, count_out, hit_out visible the cycle after acceptance.
//   - Match: compare data_in against slots with out_valid=1 only; invalid slots never
//     match (value 0x00 is a legal tracked value). At most one slot can match.
//   - Hit at slot k: slot0<=data_in; slots 1..k <= old slots 0..k-1; slots >k
//     unchanged; count unchanged; hit_out=1, hit_idx_out=k. k=0: list unchanged.
//   - Miss: slot0<=data_in; slot j<=old slot j-1 for all j>0; tail value dropped if
//     full; out_valid shifts in a 1; count+1 saturating at DEPTH; hit_out=0.
//   - data_valid_in=0: list held, hit_out=0, hit_idx_out held.
//   - clear_in=1: next cycle all slots invalid, out_data=0, count 0, hit_out=0;
//     clear wins over simultaneous data_valid_in (sample discarded).
//   - FSM (registered, drives count logic): ST_EMPTY -miss-> ST_FILL (or ST_FULL
//     if DEPTH reached); ST_FILL -miss with count=DEPTH-1-> ST_FULL; ST_FILL/ST_FULL
//     stay on hit; any state -clear_in-> ST_EMPTY. out_valid always = thermometer
//     of count_out (bits 0..count-1 set); no holes.
//   - Invariant: valid slots always hold pairwise distinct values.
// CONFIGURATION
//   MRU_EVICT_OUT_EN defined: adds ports evict_out (DATA_W) and evict_valid_out (1);
//     on a miss accepted in ST_FULL, next cycle evict_valid_out=1 pulse and
//     evict_out = dropped tail value; otherwise evict_valid_out=0, evict_out held.
//     Both reset to 0. Clear does not report evictions.
//   Not defined: ports absent, tail value discarded silently; all else identical.
// TESTING (DATA_W=8, DEPTH=4)
//   - Reset, then push 0x11,0x22,0x33 -> slots {33,22,11,--}, out_valid=4'b0111,
//     count_out=3, hit_out=0 each cycle.
//   - Then push 0x22 -> {22,33,11,--}, hit_out=1, hit_idx_out=1, count_out=3.
//   - Push 0x44,0x55 -> {44,22,33,11} then {55,44,22,33}, count_out=4 (ST_FULL);
//     with MRU_EVICT_OUT_EN: evict_valid_out=1, evict_out=0x11 after 0x55.
//   - Push 0x33 -> {33,55,44,22}, hit_idx_out=3, no eviction; push 0x33 again ->
//     list unchanged, hit_idx_out=0.
//   - From reset push 0x00 -> miss (not matched to empty slots), slot0=0x00,
//     count_out=1; then clear_in=1 with data_valid_in=1, data_in=0x77 -> count_out=0,
//     out_valid=0, out_data=0.
//   - Assert reset_in mid-stream between clock edges -> all outputs 0 before next
//     edge; deassert and push 0xAA -> {AA,--,--,--}, count_out=1.

Source files
------------

// File: rtl/mru_value_tracker.sv
// Most-recently-used tracker of the DEPTH latest distinct sample values, slot 0 newest.
// Optional eviction reporting is enabled by defining MRU_EVICT_OUT_EN.
module mru_value_tracker #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int IW    = $clog2(DEPTH)
) (
    input  logic                    clk_in,
    input  logic                    reset_in,
    input  logic [DATA_W-1:0]       data_in,
    input  logic                    data_valid_in,
    input  logic                    clear_in,
    output logic [DEPTH*DATA_W-1:0] out_data,
    output logic [DEPTH-1:0]        out_valid,
    output logic [CW-1:0]           count_out,
    output logic                    hit_out,
    output logic [IW-1:0]           hit_idx_out
`ifdef MRU_EVICT_OUT_EN
    ,
    output logic [DATA_W-1:0]       evict_out,
    output logic                    evict_valid_out
`endif
);

    typedef enum logic [1:0] {ST_EMPTY, ST_FILL, ST_FULL} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] slots_q [DEPTH];
    logic [DATA_W-1:0] slots_d [DEPTH];
    logic [CW-1:0]     count_q, count_d;
    logic              hit_q, hit_d;
    logic [IW-1:0]     hit_idx_q, hit_idx_d;
    logic [DATA_W-1:0] evict_q, evict_d;
    logic              evict_valid_q, evict_valid_d;
    logic              match;
    logic [IW-1:0]     match_idx;

    // Only occupied slots take part in the compare, so 0x00 in an empty slot never hits.
    always_comb begin
        match     = 1'b0;
        match_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if ((CW'(k) < count_q) && (slots_q[k] == data_in)) begin
                match     = 1'b1;
                match_idx = IW'(k);
            end
        end
    end

    always_comb begin
        slots_d       = slots_q;
        count_d       = count_q;
        state_d       = state_q;
        hit_d         = 1'b0;
        hit_idx_d     = hit_idx_q;
        evict_d       = evict_q;
        evict_valid_d = 1'b0;
        if (clear_in) begin
            for (int j = 0; j < DEPTH; j++) slots_d[j] = '0;
            count_d = '0;
            state_d = ST_EMPTY;
        end else if (data_valid_in) begin
            if (match) begin
                for (int j = 1; j < DEPTH; j++) begin
                    if (IW'(j) <= match_idx) slots_d[j] = slots_q[j-1];
                end
                slots_d[0] = data_in;
                hit_d      = 1'b1;
                hit_idx_d  = match_idx;
            end else begin
                for (int j = 1; j < DEPTH; j++) slots_d[j] = slots_q[j-1];
                slots_d[0] = data_in;
                if (state_q == ST_FULL) begin
                    evict_d       = slots_q[DEPTH-1];
                    evict_valid_d = 1'b1;
                end else begin
                    count_d = count_q + CW'(1);
                    state_d = (count_q == CW'(DEPTH - 1)) ? ST_FULL : ST_FILL;
                end
            end
        end
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            for (int j = 0; j < DEPTH; j++) slots_q[j] <= '0;
            count_q       <= '0;
            state_q       <= ST_EMPTY;
            hit_q         <= 1'b0;
            hit_idx_q     <= '0;
            evict_q       <= '0;
            evict_valid_q <= 1'b0;
        end else begin
            slots_q       <= slots_d;
            count_q       <= count_d;
            state_q       <= state_d;
            hit_q         <= hit_d;
            hit_idx_q     <= hit_idx_d;
            evict_q       <= evict_d;
            evict_valid_q <= evict_valid_d;
        end
    end

    // Valid flags are a thermometer of the count: occupied slots are always 0..count-1.
    always_comb begin
        out_data  = '0;
        out_valid = '0;
        for (int k = 0; k < DEPTH; k++) begin
            out_data[k*DATA_W +: DATA_W] = slots_q[k];
            out_valid[k]                 = (CW'(k) < count_q);
        end
    end

    assign count_out   = count_q;
    assign hit_out     = hit_q;
    assign hit_idx_out = hit_idx_q;

`ifdef MRU_EVICT_OUT_EN
    assign evict_out       = evict_q;
    assign evict_valid_out = evict_valid_q;
`else
    logic unused_evict;
    assign unused_evict = ^{evict_q, evict_valid_q};
`endif

endmodule
